sdl_md_tx: RTL

- Transmit-side counterpart of the byte-stream sink `sdl_md`.
- Accepts raw bytes on a valid strobe and buffers them in a small FIFO.
- Emits them as packets on an AXI-stream master interface (8-bit data); packet boundaries come from a fixed length or an explicit last flag.
- Sits in front of any `axi_stream_inf.slaver` consumer, including `sdl_md`.

---
 rtl/sdl_md_pkg.sv | 12 +
 rtl/axi_stream_inf.sv | 20 ++
 rtl/sdl_beat_fifo.sv | 47 ++++
 rtl/sdl_md_tx.sv | 104 ++++++++++
 4 files changed

// File: rtl/sdl_md_pkg.sv
// Shared types for the sdl_md byte-stream transmit path.
package sdl_md_pkg;

  localparam int SDL_BYTE_W = 8;

  typedef struct packed {
    logic [SDL_BYTE_W-1:0] data;
    logic                  keep;
    logic                  last;
  } sdl_beat_t;

endpackage

// File: rtl/axi_stream_inf.sv
// Minimal AXI-stream bundle; the master drives everything except tready.
interface axi_stream_inf #(
  parameter int DSIZE = 8
) (
  input logic aclk
);
  logic               axis_tvalid;
  logic               axis_tready;
  logic               axis_tlast;
  logic               axis_tuser;
  logic [DSIZE-1:0]   axis_tdata;
  logic [DSIZE/8-1:0] axis_tkeep;

  modport master (input aclk, input axis_tready,
                  output axis_tvalid, output axis_tdata, output axis_tlast,
                  output axis_tkeep, output axis_tuser);

  modport slaver (input aclk, input axis_tvalid, input axis_tdata, input axis_tlast,
                  input axis_tkeep, input axis_tuser, output axis_tready);
endinterface

// File: rtl/sdl_beat_fifo.sv
// Synchronous FIFO of sdl_beat_t; pointers carry one extra wrap bit so
// occupancy is a plain subtraction.
module sdl_beat_fifo
  import sdl_md_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  sdl_beat_t              wdata,
  output sdl_beat_t              rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  sdl_beat_t   mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  assign count   = wptr_q - rptr_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/sdl_md_tx.sv
// Byte-to-AXI-stream packetiser: buffers bytes, closes packets on PKT_LEN or ilast.
// Define SDL_MD_TX_TIMEOUT_EN to force-close idle open packets with a tkeep=0 terminator.
module sdl_md_tx
  import sdl_md_pkg::*;
#(
  parameter int PKT_LEN = 16,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [SDL_BYTE_W-1:0]  idata,
  input  logic                   ivalid,
  input  logic                   ilast,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] fill,
  axi_stream_inf.master          axis_out
);
  if (PKT_LEN < 1 || PKT_LEN > 65535 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1)
  begin : g_bad_cfg
    $error("sdl_md_tx: illegal parameter set");
  end

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  logic [15:0] bcnt_q, bcnt_d;
  logic        ovf_q, ovf_d;
  logic        full, empty, push, pop, wr_ok, term_req, term_push, beat_last;
  sdl_beat_t   wbeat, rbeat;

  assign beat_last = ilast || (bcnt_q == LAST_IDX);

`ifdef SDL_MD_TX_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // Down-counter reaches zero on the TIMEOUT-th idle cycle of an open packet.
  assign term_req = (bcnt_q != '0) && (tmo_q == '0);

  always_comb begin
    tmo_d = tmo_q;
    if (wr_ok || term_push || bcnt_q == '0) tmo_d = TMO_LOAD;
    else if (tmo_q != '0)                   tmo_d = tmo_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) tmo_q <= TMO_LOAD;
    else        tmo_q <= tmo_d;
  end
`else
  assign term_req = 1'b0;
`endif

  // A pending terminator owns the write port; source bytes are dropped meanwhile.
  assign term_push = term_req && !full;
  assign wr_ok     = ivalid && !full && !term_req;
  assign push      = wr_ok || term_push;
  assign pop       = !empty && axis_out.axis_tready;

  always_comb begin
    wbeat = '{data: idata, keep: 1'b1, last: beat_last};
    if (term_req) wbeat = '{data: '0, keep: 1'b0, last: 1'b1};
  end

  always_comb begin
    bcnt_d = bcnt_q;
    if (term_push)  bcnt_d = '0;
    else if (wr_ok) bcnt_d = beat_last ? 16'd0 : bcnt_q + 16'd1;
    ovf_d = ovf_q || (ivalid && !wr_ok);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      ovf_q  <= ovf_d;
    end
  end

  sdl_beat_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clock),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wbeat),
    .rdata (rbeat),
    .full  (full),
    .empty (empty),
    .count (fill)
  );

  // Empty-FIFO outputs are forced so stale storage never shows on the bus.
  assign axis_out.axis_tvalid = !empty;
  assign axis_out.axis_tdata  = empty ? '0 : rbeat.data;
  assign axis_out.axis_tlast  = !empty && rbeat.last;
  assign axis_out.axis_tkeep  = empty | rbeat.keep;
  assign axis_out.axis_tuser  = 1'b0;
  assign ovf                  = ovf_q;

endmodule
